mips_control: RTL and testbench

Main instruction decoder for the 5-stage MIPS pipeline, instantiated in the ID/EX register and the datapath stages. It decodes opcode and funct into one-hot instruction flags and derived datapath controls, combinationally and in the same cycle. It also keeps a registered copy of the control word for the next stage, with enable and synchronous flush.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/mips_control_if.sv | 38 +++
 rtl/mips_control.sv | 121 ++++++++++++
 tb/tb_mips_control.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS control block.
// Holds the opcode/funct encodings that the decoder recognises, the encodings
// of the derived datapath selects (reg_dst, ext_op, alu_op, npc_sel) and the
// bit positions of each instruction flag inside the registered control word.
package mips_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instruction bits [5:0]
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    // Destination register select
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RA    = 2'b01;
    localparam logic [1:0] RD_RD    = 2'b10;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // ALU operation
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    // Next-PC select
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BEQ  = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    // Registered control word layout; bits [2:0] are always zero
    localparam int CQ_W       = 16;
    localparam int CQ_ADDU    = 3;
    localparam int CQ_SUBU    = 4;
    localparam int CQ_CMCO    = 5;
    localparam int CQ_JR      = 6;
    localparam int CQ_ORI     = 7;
    localparam int CQ_LW      = 8;
    localparam int CQ_SW      = 9;
    localparam int CQ_BEQ     = 10;
    localparam int CQ_LUI     = 11;
    localparam int CQ_JAL     = 12;
    localparam int CQ_J       = 13;
    localparam int CQ_NOP     = 14;
    localparam int CQ_ILLEGAL = 15;

endpackage

// File: rtl/mips_control_if.sv
// Bus between the pipeline and the instruction decoder.
//   master (pipeline side): drives op, fuc, en, clear; receives decode results.
//   slave  (decoder side) : receives op, fuc, en, clear; drives the one-hot
//                           flags, illegal, the datapath selects and ctrl_q.
interface mips_control_if;
    import mips_pkg::*;

    logic [5:0]      op;
    logic [5:0]      fuc;
    logic            en;
    logic            clear;

    logic            addu, subu, cmco, jr, ori, lw, sw, beq, lui, jal, j, nop;
    logic            illegal;
    logic [1:0]      reg_dst;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic [1:0]      ext_op;
    logic [2:0]      alu_op;
    logic [1:0]      npc_sel;
    logic [CQ_W-1:0] ctrl_q;

    modport master (
        output op, fuc, en, clear,
        input  addu, subu, cmco, jr, ori, lw, sw, beq, lui, jal, j, nop,
        input  illegal, reg_dst, reg_write, mem_write, mem_to_reg, alu_src,
        input  ext_op, alu_op, npc_sel, ctrl_q
    );

    modport slave (
        input  op, fuc, en, clear,
        output addu, subu, cmco, jr, ori, lw, sw, beq, lui, jal, j, nop,
        output illegal, reg_dst, reg_write, mem_write, mem_to_reg, alu_src,
        output ext_op, alu_op, npc_sel, ctrl_q
    );
endinterface

// File: rtl/mips_control.sv
// Main instruction decoder for the 5-stage MIPS pipeline.
// Decodes op/fuc into one-hot instruction flags plus derived datapath
// controls, all combinational. A registered copy of the flag word (ctrl_q)
// feeds the next stage; clear inserts a bubble and wins over en.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; clears ctrl_q
//   bus   - mips_control_if.slave (op, fuc, en, clear in; flags, selects,
//           ctrl_q out)
module mips_control
    import mips_pkg::*;
#(
    parameter logic [5:0] CMCO_FUNCT = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    mips_control_if.slave      bus
);

    logic            w_rtype;
    logic            w_addu, w_subu, w_cmco, w_jr, w_nop;
    logic            w_ori, w_lw, w_sw, w_beq, w_lui, w_jal, w_j;
    logic            w_illegal;
    logic [CQ_W-1:0] w_word;
    logic [CQ_W-1:0] r_ctrl_q;

    // Flag decode. Each flag is an exact match, so at most one can be high;
    // illegal covers every encoding none of them claim.
    always_comb begin
        w_rtype   = (bus.op == OP_RTYPE);
        w_addu    = w_rtype && (bus.fuc == FN_ADDU);
        w_subu    = w_rtype && (bus.fuc == FN_SUBU);
        w_jr      = w_rtype && (bus.fuc == FN_JR);
        w_cmco    = w_rtype && (bus.fuc == CMCO_FUNCT);
        w_nop     = w_rtype && (bus.fuc == FN_NOP);
        w_ori     = (bus.op == OP_ORI);
        w_lw      = (bus.op == OP_LW);
        w_sw      = (bus.op == OP_SW);
        w_beq     = (bus.op == OP_BEQ);
        w_lui     = (bus.op == OP_LUI);
        w_jal     = (bus.op == OP_JAL);
        w_j       = (bus.op == OP_J);
        w_illegal = ~|{w_addu, w_subu, w_cmco, w_jr, w_nop, w_ori,
                       w_lw, w_sw, w_beq, w_lui, w_jal, w_j};

        w_word              = '0;
        w_word[CQ_ADDU]     = w_addu;
        w_word[CQ_SUBU]     = w_subu;
        w_word[CQ_CMCO]     = w_cmco;
        w_word[CQ_JR]       = w_jr;
        w_word[CQ_ORI]      = w_ori;
        w_word[CQ_LW]       = w_lw;
        w_word[CQ_SW]       = w_sw;
        w_word[CQ_BEQ]      = w_beq;
        w_word[CQ_LUI]      = w_lui;
        w_word[CQ_JAL]      = w_jal;
        w_word[CQ_J]        = w_j;
        w_word[CQ_NOP]      = w_nop;
        w_word[CQ_ILLEGAL]  = w_illegal;
    end

    // Derived datapath controls. Everything stays zero on an illegal
    // encoding so it behaves as a bubble; ext_op defaults to the lui shift
    // for every legal instruction that does not name another extension.
    always_comb begin
        bus.reg_dst    = RD_RT;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.ext_op     = EXT_ZERO;
        bus.alu_op     = ALU_ADD;
        bus.npc_sel    = NPC_PC4;

        if (!w_illegal) begin
            if (w_addu || w_subu || w_cmco) bus.reg_dst = RD_RD;
            else if (w_jal)                 bus.reg_dst = RD_RA;

            bus.reg_write  = w_addu | w_subu | w_cmco | w_ori | w_lw | w_lui | w_jal;
            bus.mem_write  = w_sw;
            bus.mem_to_reg = w_lw;
            bus.alu_src    = w_ori | w_lw | w_sw | w_lui;

            if (w_lw || w_sw || w_beq) bus.ext_op = EXT_SIGN;
            else if (w_ori)            bus.ext_op = EXT_ZERO;
            else                       bus.ext_op = EXT_LUI;

            if (w_subu || w_beq)      bus.alu_op = ALU_SUB;
            else if (w_ori || w_cmco) bus.alu_op = ALU_OR;
            else if (w_lui)           bus.alu_op = ALU_PASSB;

            // beq only selects the target; taken/not-taken is resolved by
            // the comparator outside this block.
            if (w_beq)            bus.npc_sel = NPC_BEQ;
            else if (w_j || w_jal) bus.npc_sel = NPC_JUMP;
            else if (w_jr)        bus.npc_sel = NPC_JR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_ctrl_q <= '0;
        else if (bus.clear) r_ctrl_q <= '0;
        else if (bus.en)    r_ctrl_q <= w_word;
    end

    assign bus.addu    = w_addu;
    assign bus.subu    = w_subu;
    assign bus.cmco    = w_cmco;
    assign bus.jr      = w_jr;
    assign bus.ori     = w_ori;
    assign bus.lw      = w_lw;
    assign bus.sw      = w_sw;
    assign bus.beq     = w_beq;
    assign bus.lui     = w_lui;
    assign bus.jal     = w_jal;
    assign bus.j       = w_j;
    assign bus.nop     = w_nop;
    assign bus.illegal = w_illegal;
    assign bus.ctrl_q  = r_ctrl_q;

endmodule

// File: tb/tb_mips_control.sv
// Self-checking bench for mips_control: a table-driven reference model of the
// decoder and a behavioural copy of the control-word register, compared on
// every falling clock edge, plus hand-written literal expectations.
module tb_mips_control;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    bit   cmp_on;

    mips_control_if bus();

    mips_control #(.CMCO_FUNCT(6'b111111)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ids: 0 addu,1 subu,2 cmco,3 jr,4 ori,5 lw,6 sw,7 beq,
    // 8 lui,9 jal,10 j,11 nop,12 illegal. ctrl_q bit for id k is k+3.
    function automatic int instr_id(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'b100001) return 0;
            if (fn == 6'b100011) return 1;
            if (fn == 6'b111111) return 2;
            if (fn == 6'b001000) return 3;
            if (fn == 6'b000000) return 11;
            return 12;
        end
        if (op == 6'b001101) return 4;
        if (op == 6'b100011) return 5;
        if (op == 6'b101011) return 6;
        if (op == 6'b000100) return 7;
        if (op == 6'b001111) return 8;
        if (op == 6'b000011) return 9;
        if (op == 6'b000010) return 10;
        return 12;
    endfunction

    // Control table: {reg_dst, reg_write, mem_write, mem_to_reg, alu_src,
    //                 ext_op, alu_op, npc_sel}
    function automatic logic [12:0] ctl_of(input int id);
        case (id)
            0:  return {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00};
            1:  return {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b001, 2'b00};
            2:  return {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b010, 2'b00};
            3:  return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b11};
            4:  return {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 2'b00};
            5:  return {2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 2'b00};
            6:  return {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 2'b00};
            7:  return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 2'b01};
            8:  return {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 3'b011, 2'b00};
            9:  return {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b10};
            10: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b10};
            11: return {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00};
            default: return 13'd0;
        endcase
    endfunction

    function automatic logic [15:0] word_of(input int id);
        logic [15:0] one;
        one = 16'd1;
        return one << (id + 3);
    endfunction

    // DUT outputs packed into the bench's own orderings
    logic [11:0] dut_flags;
    logic [12:0] dut_ctl;
    assign dut_flags = {bus.nop, bus.j, bus.jal, bus.lui, bus.beq, bus.sw, bus.lw,
                        bus.ori, bus.jr, bus.cmco, bus.subu, bus.addu};
    assign dut_ctl   = {bus.reg_dst, bus.reg_write, bus.mem_write, bus.mem_to_reg,
                        bus.alu_src, bus.ext_op, bus.alu_op, bus.npc_sel};

    // Behavioural register model
    logic [15:0] mdl_q;
    always @(posedge clk or posedge reset) begin
        if (reset)          mdl_q <= 16'd0;
        else if (bus.clear) mdl_q <= 16'd0;
        else if (bus.en)    mdl_q <= word_of(instr_id(bus.op, bus.fuc));
    end

    // Compare process
    always @(negedge clk) begin
        if (cmp_on) begin
            int          id;
            logic [11:0] ef;
            id = instr_id(bus.op, bus.fuc);
            ef = (id < 12) ? (12'd1 << id) : 12'd0;
            n_checks++;
            if (dut_flags !== ef || bus.illegal !== (id == 12)) begin
                n_errors++;
                $display("FAIL flags op=%b fuc=%b: got %b/ill=%b want %b/ill=%b",
                         bus.op, bus.fuc, dut_flags, bus.illegal, ef, id == 12);
            end
            n_checks++;
            if ($countones(dut_flags) + int'(bus.illegal) != 1) begin
                n_errors++;
                $display("FAIL onehot op=%b fuc=%b: got %0d high want 1",
                         bus.op, bus.fuc, $countones(dut_flags) + int'(bus.illegal));
            end
            n_checks++;
            if (dut_ctl !== ctl_of(id)) begin
                n_errors++;
                $display("FAIL ctl op=%b fuc=%b: got %b want %b",
                         bus.op, bus.fuc, dut_ctl, ctl_of(id));
            end
            n_checks++;
            if (bus.ctrl_q !== mdl_q) begin
                n_errors++;
                $display("FAIL ctrl_q: got %h want %h", bus.ctrl_q, mdl_q);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic en, input logic clr);
        @(posedge clk);
        #2;
        bus.op    = op;
        bus.fuc   = fn;
        bus.en    = en;
        bus.clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] vops [8];
    logic [5:0] vfns [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        cmp_on   = 1'b0;
        vops = '{6'b000000, 6'b001101, 6'b100011, 6'b101011,
                 6'b000100, 6'b001111, 6'b000011, 6'b000010};
        vfns = '{6'b100001, 6'b100011, 6'b001000, 6'b111111, 6'b000000};
        reset = 1'b1;
        bus.op = 6'd0; bus.fuc = 6'd0; bus.en = 1'b0; bus.clear = 1'b0;
        #3;
        lit("reset_ctrl_q", bus.ctrl_q, 16'h0000);
        tick();
        lit("reset_held_ctrl_q", bus.ctrl_q, 16'h0000);
        #1 reset = 1'b0;
        cmp_on = 1'b1;

        // Literal pins of the decode table
        drive(6'b000000, 6'b100001, 1'b0, 1'b0); #1;
        lit("addu_flag", {15'd0, bus.addu}, 16'd1);
        lit("addu_ctl", {3'd0, dut_ctl}, {3'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00});
        lit("addu_illegal", {15'd0, bus.illegal}, 16'd0);
        drive(6'b100011, 6'b010101, 1'b0, 1'b0); #1;
        lit("lw_ctl", {bus.lw, 2'd0, dut_ctl}, {1'b1, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 2'b00});
        drive(6'b101011, 6'b000000, 1'b0, 1'b0); #1;
        lit("sw_ctl", {bus.sw, 2'd0, dut_ctl}, {1'b1, 2'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 2'b00});
        drive(6'b000011, 6'b111111, 1'b0, 1'b0); #1;
        lit("jal_ctl", {bus.jal, 2'd0, dut_ctl}, {1'b1, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b10});
        drive(6'b000000, 6'b001000, 1'b0, 1'b0); #1;
        lit("jr_ctl", {bus.jr, 2'd0, dut_ctl}, {1'b1, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b11});
        drive(6'b000000, 6'b000111, 1'b0, 1'b0); #1;
        lit("illegal_rtype", {bus.illegal, 2'd0, dut_ctl}, 16'h8000);
        drive(6'b111111, 6'b100001, 1'b0, 1'b0); #1;
        lit("illegal_op", {bus.illegal, 2'd0, dut_ctl}, 16'h8000);
        drive(6'b000000, 6'b111111, 1'b0, 1'b0); #1;
        lit("cmco_ctl", {bus.cmco, 2'd0, dut_ctl}, {1'b1, 2'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b010, 2'b00});

        // Register behaviour with literal words
        drive(6'b001101, 6'd0, 1'b1, 1'b0); tick();
        lit("ori_loaded", bus.ctrl_q, 16'h0080);
        drive(6'b001101, 6'd0, 1'b1, 1'b1); tick();
        lit("clear_wins", bus.ctrl_q, 16'h0000);
        drive(6'b001101, 6'd0, 1'b1, 1'b0); tick();
        lit("ori_reloaded", bus.ctrl_q, 16'h0080);
        drive(6'b001111, 6'd0, 1'b0, 1'b0); tick();
        lit("en0_holds", bus.ctrl_q, 16'h0080);
        drive(6'b001111, 6'd0, 1'b1, 1'b0); tick();
        lit("lui_loaded", bus.ctrl_q, 16'h0800);
        #3 reset = 1'b1;
        #1 lit("async_reset", bus.ctrl_q, 16'h0000);
        tick(); tick();
        lit("reset_held", bus.ctrl_q, 16'h0000);
        #2 reset = 1'b0;
        #1 lit("post_release", bus.ctrl_q, 16'h0000);
        tick();
        lit("first_edge_load", bus.ctrl_q, 16'h0800);

        // Exhaustive op/fuc sweep with random en/clear
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] v;
            v = 12'(i);
            drive(v[11:6], v[5:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        // Biased random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) < 7) ? vops[$urandom_range(0, 7)] : 6'($urandom);
            fn = ($urandom_range(0, 9) < 6) ? vfns[$urandom_range(0, 4)] : 6'($urandom);
            drive(op, fn, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
        end

        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
